// File: rtl/keyboard_event_queue.sv
// Keyboard event FIFO with a CPU register window (peek/pop/status/flush/irq-enable).
// Define KEYBOARD_EVENT_QUEUE_MAKE_ONLY_EN to discard key-release events before they reach the FIFO.
module keyboard_event_queue #(
  parameter int DEPTH = 16
) (
  input  logic        global_clk,
  input  logic        global_reset_n,
  input  logic        key_valid,
  input  logic [15:0] key_set1,
  input  logic [15:0] key_ascii,
  input  logic        key_break,
  input  logic [15:0] ram_addr,
  input  logic        ram_rd,
  input  logic        ram_wr,
  input  logic [15:0] ram_wdata,
  output logic [15:0] ram_rdata,
  output logic        kb_irq
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [32:0]    mem [DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]  count;
  logic           overflow, irq_en;

  logic [32:0]    head;
  logic           empty, full, rd_only, pop, flush, ctl_wr;
  logic           key_ok, push, ovf_set, head_brk;
  logic [15:0]    status, rd_mux;

  assign head    = mem[rd_ptr];
  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  // A read colliding with a write is suppressed entirely, including the pop side effect.
  assign rd_only = ram_rd && !ram_wr;
  assign pop     = rd_only && (ram_addr == 16'h0003) && !empty;
  assign flush   = ram_wr && (ram_addr == 16'h0004);
  assign ctl_wr  = ram_wr && (ram_addr == 16'h0002);

`ifdef KEYBOARD_EVENT_QUEUE_MAKE_ONLY_EN
  logic unused_bits;
  assign key_ok      = key_valid && !key_break;
  assign head_brk    = 1'b0;
  assign unused_bits = ^{head[32], ram_wdata[14], ram_wdata[12:0]};
`else
  logic unused_bits;
  assign key_ok      = key_valid;
  assign head_brk    = head[32] && !empty;
  assign unused_bits = ^{ram_wdata[14], ram_wdata[12:0]};
`endif

  // A same-cycle pop frees the slot the incoming push needs, so a full queue still accepts it.
  assign push    = key_ok && !flush && (!full || pop);
  assign ovf_set = key_ok && !flush && full && !pop;

  assign status  = {overflow, head_brk, irq_en, 5'b0, 8'(count)};

  always_comb begin
    rd_mux = 16'h0000;
    if (rd_only) begin
      case (ram_addr)
        16'h0000: rd_mux = empty ? 16'h0000 : head[15:0];
        16'h0001: rd_mux = empty ? 16'h0000 : head[31:16];
        16'h0002: rd_mux = status;
        16'h0003: rd_mux = empty ? 16'h0000 : head[15:0];
        default:  rd_mux = 16'h0000;
      endcase
    end
  end

  // Entry storage carries no reset; only pointers and count define its contents.
  always_ff @(posedge global_clk) begin
    if (push) mem[wr_ptr] <= {key_break, key_ascii, key_set1};
  end

  always_ff @(posedge global_clk or negedge global_reset_n) begin
    if (!global_reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      irq_en    <= 1'b0;
      ram_rdata <= 16'h0000;
      kb_irq    <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
      if (ovf_set)
        overflow <= 1'b1;
      else if (ctl_wr && ram_wdata[15])
        overflow <= 1'b0;
      if (ctl_wr) irq_en <= ram_wdata[13];
      if (ram_rd) ram_rdata <= rd_mux;
      kb_irq <= irq_en && !empty;
    end
  end

endmodule

// File: tb/tb_keyboard_event_queue.sv
// Directed bench for keyboard_event_queue: read results go through an expected-value queue.
module tb_keyboard_event_queue;

  logic        global_clk = 1'b0;
  logic        global_reset_n = 1'b0;
  logic        key_valid = 1'b0;
  logic [15:0] key_set1 = '0;
  logic [15:0] key_ascii = '0;
  logic        key_break = 1'b0;
  logic [15:0] ram_addr = '0;
  logic        ram_rd = 1'b0;
  logic        ram_wr = 1'b0;
  logic [15:0] ram_wdata = '0;
  logic [15:0] ram_rdata;
  logic        kb_irq;

  int checks = 0;
  int failures = 0;
  logic [15:0] exp_q [$];
  string       tag_q [$];

  keyboard_event_queue #(.DEPTH(16)) dut (
    .global_clk(global_clk), .global_reset_n(global_reset_n),
    .key_valid(key_valid), .key_set1(key_set1), .key_ascii(key_ascii), .key_break(key_break),
    .ram_addr(ram_addr), .ram_rd(ram_rd), .ram_wr(ram_wr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .kb_irq(kb_irq)
  );

  always #5 global_clk = ~global_clk;

  task automatic chk(input logic [15:0] obs, input logic [15:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_rdata();
    logic [15:0] e;
    string t;
    if (exp_q.size() == 0) begin
      chk(ram_rdata, 16'hxxxx, "scoreboard_empty");
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      chk(ram_rdata, e, t);
    end
  endtask

  // One bus/key cycle driven at the falling edge; any read result is checked one cycle later.
  task automatic step(input logic kv, input logic [15:0] s1, input logic [15:0] asc, input logic brk,
                      input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] wd,
                      input logic [15:0] exp, input string tag);
    @(negedge global_clk);
    key_valid = kv; key_set1 = s1; key_ascii = asc; key_break = brk;
    ram_rd = rd; ram_wr = wr; ram_addr = a; ram_wdata = wd;
    if (rd) begin
      exp_q.push_back(exp);
      tag_q.push_back(tag);
    end
    @(negedge global_clk);
    key_valid = 1'b0; ram_rd = 1'b0; ram_wr = 1'b0;
    if (rd) check_rdata();
  endtask

  task automatic rd(input logic [15:0] a, input logic [15:0] exp, input string tag);
    step(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0, a, 16'h0, exp, tag);
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, a, d, 16'h0, "");
  endtask

  task automatic push(input logic [15:0] s1, input logic [15:0] asc, input logic brk);
    step(1'b1, s1, asc, brk, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, "");
  endtask

  initial begin
    // Reset
    repeat (3) @(negedge global_clk);
    chk(ram_rdata, 16'h0000, "reset_rdata");
    chk({15'b0, kb_irq}, 16'h0000, "reset_irq");
    global_reset_n = 1'b1;
    rd(16'h0002, 16'h0000, "reset_status");

    // Single event, interrupt rise and fall
    wr(16'h0002, 16'h2000);
    push(16'h001E, 16'h0061, 1'b0);
    chk({15'b0, kb_irq}, 16'h0000, "irq_not_yet");
    @(negedge global_clk);
    chk({15'b0, kb_irq}, 16'h0001, "irq_rise");
    rd(16'h0002, 16'h2001, "status_one");
    rd(16'h0000, 16'h001E, "peek_set1");
    rd(16'h0001, 16'h0061, "peek_ascii");
    rd(16'h0003, 16'h001E, "pop_one");
    chk({15'b0, kb_irq}, 16'h0001, "irq_hold_after_pop");
    rd(16'h0002, 16'h2000, "status_empty");
    chk({15'b0, kb_irq}, 16'h0000, "irq_fall");
    @(negedge global_clk);
    chk(ram_rdata, 16'h2000, "rdata_held");

    // Overflow: DEPTH+2 pushes, set beats clear, in-order pops
    wr(16'h0002, 16'h0000);
    for (int i = 1; i <= 18; i++) push(16'(i), 16'(16'h0100 + i), 1'b0);
    rd(16'h0002, 16'h8010, "status_overflow");
    chk({15'b0, kb_irq}, 16'h0000, "irq_disabled");
    step(1'b1, 16'h0077, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0002, 16'h8000, 16'h0, "");
    rd(16'h0002, 16'h8010, "ovf_set_wins");
    for (int i = 1; i <= 16; i++) rd(16'h0003, 16'(i), $sformatf("pop_order_%0d", i));
    rd(16'h0003, 16'h0000, "pop_after_drain");
    wr(16'h0002, 16'h8000);
    rd(16'h0002, 16'h0000, "ovf_cleared");

    // Full queue with simultaneous push and pop
    for (int i = 1; i <= 16; i++) push(16'(16'h0020 + i), 16'h0000, 1'b0);
    rd(16'h0002, 16'h0010, "status_full");
    step(1'b1, 16'h0055, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0003, 16'h0, 16'h0021, "full_push_pop");
    rd(16'h0002, 16'h0010, "full_no_ovf");
    for (int i = 2; i <= 16; i++) rd(16'h0003, 16'(16'h0020 + i), $sformatf("pop_full_%0d", i));
    rd(16'h0003, 16'h0055, "pop_newest_last");
    rd(16'h0002, 16'h0000, "status_drained");

    // Empty pops, unmapped reads, read+write collision
    rd(16'h0003, 16'h0000, "pop_empty");
    rd(16'h0002, 16'h0000, "count_stays_zero");
    rd(16'h0005, 16'h0000, "unmapped_read");
    step(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b1, 16'h0002, 16'h2000, 16'h0000, "rd_wr_collision");
    rd(16'h0002, 16'h2000, "write_took_effect");

    // Flush coincident with a key event
    for (int i = 0; i < 5; i++) push(16'(16'h0040 + i), 16'h0000, 1'b0);
    rd(16'h0002, 16'h2005, "status_five");
    chk({15'b0, kb_irq}, 16'h0001, "irq_five");
    step(1'b1, 16'h0099, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0004, 16'h1234, 16'h0, "");
    rd(16'h0002, 16'h2000, "status_flushed");
    chk({15'b0, kb_irq}, 16'h0000, "irq_after_flush");

    // Break event
    push(16'h009E, 16'h0000, 1'b1);
`ifdef KEYBOARD_EVENT_QUEUE_MAKE_ONLY_EN
    rd(16'h0002, 16'h2000, "break_discarded");
    chk({15'b0, kb_irq}, 16'h0000, "break_no_irq");
`else
    rd(16'h0002, 16'h6001, "break_status");
    rd(16'h0000, 16'h009E, "break_peek");
    rd(16'h0003, 16'h009E, "break_pop");
    rd(16'h0002, 16'h2000, "break_drained");
`endif

    chk(16'(exp_q.size()), 16'h0000, "scoreboard_leftover");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/keyboard_event_queue.md
# keyboard_event_queue

Buffers decoded keyboard events (set-1 scan code, ASCII code, break flag) in a FIFO so no key is lost while the CPU is busy. Sits between the keyboard decode chain and the CPU memory bus and replaces direct register sampling of the last key. Provides a small register window with peek, pop, status, flush and interrupt-enable, and raises a level interrupt while events are pending.

## Interface
- DEPTH, 16, FIFO entries; power of two, 2..128
- global_clk  in  1  system clock; all logic on rising edge
- global_reset_n  in  1  asynchronous, active-low reset
- key_valid  in  1  one-cycle strobe: a new event is present on key_set1/key_ascii/key_break
- key_set1  in  16  set-1 scan code of event
- key_ascii  in  16  ASCII code of event (0 if none)
- key_break  in  1  1 = key release, 0 = key press
- ram_addr  in  16  CPU register address
- ram_rd  in  1  CPU read strobe, one cycle
- ram_wr  in  1  CPU write strobe, one cycle
- ram_wdata  in  16  CPU write data
- ram_rdata  out  16  registered read data
- kb_irq  out  1  registered interrupt request, level

## Operation
- Entry = {key_break, key_ascii, key_set1}, 33 bits; head = oldest entry.
- Register map (reads use ram_rd; unmapped reads return 0x0000):
  - 0x0000 read: head set1, no pop (0x0000 if empty)
  - 0x0001 read: head ASCII, no pop (0x0000 if empty)
  - 0x0002 read: status [15]=overflow (sticky), [14]=head break flag, [13]=irq_en, [12:8]=0, [7:0]=count
  - 0x0002 write: [13] loads irq_en; [15]=1 clears overflow; other bits ignored
  - 0x0003 read: head set1 and pop; empty → returns 0x0000, no state change
  - 0x0004 write (any data): flush, count=0, pointers reset; overflow and irq_en unchanged
- Push: key_valid=1 and count<DEPTH → entry written at tail, count+1.
- Full: key_valid=1 and count==DEPTH → event dropped, overflow set to 1.
- Simultaneous push and pop: both take effect, count unchanged; when full, a push coincident with a pop is accepted (no overflow).
- Push with empty FIFO and pop same cycle: pop sees empty (returns 0), push accepted.
- Flush coincident with push: flush wins, event dropped, overflow not set.
- Overflow write-clear coincident with new overflow: set wins.
- Pointers wrap modulo DEPTH; count width log2(DEPTH)+1, zero-extended into status[7:0].
- ram_rd and ram_wr asserted together: the write is performed, the read returns 0x0000.
- kb_irq = irq_en && count!=0, registered.

## Timing
- Reset (async assert, sync deassert by system): ram_rdata=0x0000, kb_irq=0, count=0, pointers=0, overflow=0, irq_en=0; FIFO storage not cleared.
- Read latency 1: ram_rd in cycle N → ram_rdata valid N+1, held until next ram_rd; ram_rdata reflects state before any same-cycle push/pop/write.
- Pop/push/write effects visible to count in cycle N+1.
- kb_irq follows count/irq_en with 1 cycle of delay: event pushed in N (irq_en=1, was empty) → kb_irq=1 at N+2 edge output, i.e. visible in cycle N+2; drops 1 cycle after the pop that empties the queue becomes visible.
- No backpressure on key_valid; producer never stalls.

## Configuration
- KEYBOARD_EVENT_QUEUE_MAKE_ONLY_EN defined: events with key_break=1 are discarded before the FIFO (never counted, never set overflow); status[14] reads 0.
- Undefined: make and break events both queued as described above.

## Test plan
- Reset, write 0x2000 to 0x0002, push set1=0x001E ascii=0x0061 → status reads 0x2001, kb_irq=1 two cycles after push, read 0x0003 returns 0x001E, then status 0x2000, kb_irq falls.
- Push DEPTH+2 events (set1=1..18) → count=16, overflow=1 (status 0x8010), pops return 1..16 in order, 17 and 18 absent; write 0x8000 to 0x0002 clears overflow.
- Full queue, push and pop in same cycle → no overflow, count stays 16, newest entry appears as last pop.
- Read 0x0003 on empty → 0x0000, count stays 0; read 0x0005 → 0x0000.
- Queue 5 events, write 0x0004 coincident with a key_valid → count=0, kb_irq=0, overflow=0.
- Push break event set1=0x009E: macro undefined → status[14]=1, count=1; macro defined → count=0, no overflow.
